// File: rtl/uart_pkg.sv
// Shared definitions for the UART program-loading path: loader state
// encoding, the receiver's "no word yet" address marker and the baud divisor
// the receiver is built with.
package uart_pkg;

   localparam logic [1:0] LDR_IDLE    = 2'd0;
   localparam logic [1:0] LDR_LOAD    = 2'd1;
   localparam logic [1:0] LDR_RELEASE = 2'd2;

   // The receiver reports this address until its first word is assembled.
   localparam logic [31:0] NO_ADDR = 32'hFFFF_FFFF;

   // Clock cycles per UART bit, shared with the word receiver.
   localparam int BAUD_DIV = 10417;

   typedef enum logic [1:0] {
      ST_IDLE    = LDR_IDLE,
      ST_LOAD    = LDR_LOAD,
      ST_RELEASE = LDR_RELEASE
   } ldr_state_t;

endpackage

// File: rtl/uart_prog_loader_edge_rise_det.sv
// edge_rise_det: registers a level flag and reports its 0->1 transitions as
// a single-cycle pulse. A synchronous "set" preloads the history register
// with 1, so a level that is already high is not mistaken for a new rise.
module edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic d,
   output logic q,
   output logic rise
);

   // History register: follows d, forced high on set, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else if (set) begin
         q <= 1'b1;
      end else begin
         q <= d;
      end
   end

   assign rise = d & ~q;

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: converts the UART word receiver's level write flag into
// single-cycle instruction-memory writes, checks that words arrive in order
// and in range, and holds the CPU in reset while loading plus a fixed
// RELEASE_CYCLES tail after enable falls.
// Optional build macro UART_PROG_LOADER_CHECKSUM_EN adds a running 32-bit
// checksum of accepted words that must match exp_sum for a load to pass.
module uart_prog_loader
   import uart_pkg::*;
#(
   parameter int AW             = 6,
   parameter int RELEASE_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [31:0]   rx_addr,
   input  logic [31:0]   rx_data,
   input  logic          rx_wr,
`ifdef UART_PROG_LOADER_CHECKSUM_EN
   input  logic [31:0]   exp_sum,
   output logic [31:0]   checksum,
`endif
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_rst,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   word_count
);

   localparam int          DEPTH    = 2 ** AW;
   localparam logic [31:0] DEPTH32  = 32'(DEPTH);
   localparam logic [AW:0] DEPTH_W  = {1'b1, {AW{1'b0}}};
   localparam logic [15:0] REL_INIT = 16'(RELEASE_CYCLES - 1);

   ldr_state_t  state;
   logic [AW:0] exp_addr;      // next address we are willing to accept
   logic [15:0] rel_cnt;       // cycles left before the CPU is released

   logic        rx_wr_q;
   logic        wr_rise;
   logic        enter_load;
   logic        strobe;
   logic [31:0] exp_ext;
   logic        addr_none;
   logic        addr_dup;
   logic        addr_ok;

   // A fresh load starts from IDLE or by re-raising enable during RELEASE.
   assign enter_load = enable & ((state == ST_IDLE) | (state == ST_RELEASE));

   edge_rise_det u_wr_edge (
      .clk  (clk),
      .rst  (rst),
      .set  (enter_load),
      .d    (rx_wr),
      .q    (rx_wr_q),
      .rise (wr_rise)
   );

   assign strobe = wr_rise & (state == ST_LOAD);

   // Word classification; the priority order is applied in the FSM below.
   assign exp_ext   = {{(31 - AW){1'b0}}, exp_addr};
   assign addr_none = (rx_addr == NO_ADDR);
   assign addr_dup  = (word_count != '0) && (rx_addr == exp_ext - 32'd1);
   assign addr_ok   = (rx_addr == exp_ext) && (rx_addr < DEPTH32);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
   logic sum_ok;
   assign sum_ok = (checksum == exp_sum);
`endif

   // Loader FSM with registered outputs; a write is staged one cycle after
   // its strobe, so a reset on that edge cancels it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         word_count <= '0;
         exp_addr   <= '0;
         rel_cnt    <= '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               cpu_rst <= 1'b0;
            end
            ST_LOAD: begin
               cpu_rst <= 1'b1;
               if (!enable) begin
                  // Any strobe in this cycle is deliberately dropped.
                  state   <= ST_RELEASE;
                  rel_cnt <= REL_INIT;
               end else if (strobe) begin
                  if (addr_none || addr_dup) begin
                     // No word yet, or a repeat of the last one: ignore.
                  end else if (addr_ok) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= rx_addr[AW-1:0];
                     imem_wdata <= rx_data;
                     exp_addr   <= exp_addr + 1'b1;
                     if (word_count != DEPTH_W) begin
                        word_count <= word_count + 1'b1;
                     end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                     checksum   <= checksum + rx_data;
`endif
                  end else begin
                     load_err <= 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               cpu_rst <= 1'b1;
               if (rel_cnt == '0) begin
                  state   <= ST_IDLE;
                  cpu_rst <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                  load_done <= ~load_err & sum_ok;
                  if (!sum_ok) begin
                     load_err <= 1'b1;
                  end
`else
                  load_done <= ~load_err;
`endif
               end else begin
                  rel_cnt <= rel_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Entering LOAD overrides the per-state updates with a full clear.
         if (enter_load) begin
            state      <= ST_LOAD;
            cpu_rst    <= 1'b1;
            word_count <= '0;
            exp_addr   <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
         end
      end
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits directly downstream of the UART word receiver and upstream of the instruction memory write port and CPU reset.
- Turns the receiver's level-style write flag into single-cycle memory writes.
- Checks address sequencing and range, holds the CPU in reset while a program loads, and releases it after a fixed delay once loading ends.

Parameters:
- AW, 6: imem word-address width; DEPTH = 2**AW words.
- RELEASE_CYCLES, 16: cycles cpu_rst stays high after enable falls; valid range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  load-mode request; the same signal drives the receiver's enable
- rx_addr  in  32  word address from the receiver; 0xFFFFFFFF means no word yet
- rx_data  in  32  assembled word from the receiver
- rx_wr  in  1  receiver write flag; level signal that rises once per completed word
- imem_we  out  1  one-cycle write strobe to the instruction memory
- imem_addr  out  AW  write word address
- imem_wdata  out  32  write data
- cpu_rst  out  1  CPU reset request; high while loading or releasing
- load_done  out  1  sticky flag: the last load finished with no error
- load_err  out  1  sticky flag: an out-of-order or out-of-range word was received
- word_count  out  AW+1  count of words written in the current load

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, load_done=0, load_err=0, word_count=0, state=IDLE, rx_wr_q=0, expected address=0.
- Edge detect:
  - rx_wr_q <= rx_wr every cycle.
  - strobe = rx_wr & ~rx_wr_q & (state==LOAD).
- States:
  - IDLE: cpu_rst=0. When enable=1, go to LOAD next cycle. On that transition clear word_count, clear the expected address, clear load_done and load_err, and set rx_wr_q to 1 so the receiver's initial wr level is not taken as a word.
  - LOAD: cpu_rst=1. Each strobe is classified in priority order:
    - a) rx_addr==0xFFFFFFFF: ignore.
    - b) rx_addr == expected-1 and word_count>0: duplicate; ignore, no error.
    - c) rx_addr == expected and rx_addr < DEPTH: accept. The cycle after the strobe, imem_we=1 with imem_addr=rx_addr[AW-1:0] and imem_wdata=rx_data, so latency is 1 cycle. Then expected+1 and word_count+1.
    - d) anything else: set load_err; no write; expected is unchanged.
    - When enable=0, go to RELEASE with release counter = RELEASE_CYCLES-1. A strobe in that same cycle is dropped.
  - RELEASE: cpu_rst=1; the counter decrements each cycle. At 0, go to IDLE, cpu_rst drops in the same edge, and load_done <= ~load_err. If enable=1 during RELEASE, go back to LOAD with a full clear.
- imem_we is never high for two consecutive cycles; each strobe needs a 0→1 transition of rx_wr.
- word_count saturates at DEPTH; writes past DEPTH are caught by rule d.
- A rst assertion mid-load returns all outputs to reset values at the next edge. Any write already staged for that edge is cancelled.

Optional Feature:
- Macro: UART_PROG_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [31:0], reset 0 and cleared on entry to LOAD.
  - On each accepted write, checksum <= checksum + rx_data, mod 2^32.
  - Adds input exp_sum [31:0]. At RELEASE→IDLE, load_done = ~load_err & (checksum==exp_sum); a mismatch also sets load_err.
- When undefined: neither port exists and load_done depends on load_err only.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams LDR_IDLE=2'd0, LDR_LOAD=2'd1, LDR_RELEASE=2'd2;
  - NO_ADDR=32'hFFFFFFFF;
  - the baud divisor constant shared with the receiver (10417).
- One natural sub-module, edge_rise_det (registered input, rise pulse output), reusable for other level-to-pulse flags.
- The rest stays flat.

Test Plan:
- Reset then enable=1: rx_wr already high with rx_addr=0xFFFFFFFF → no imem_we, cpu_rst=1 one cycle after enable.
- Words at addresses 0,1,2 with data 0x00000013, 0x00100093, 0xDEADBEEF → three single-cycle imem_we pulses, one cycle after each rx_wr rise, with matching addr/data; word_count=3.
- rx_wr glitches low and high again with rx_addr=1 just accepted → no write, load_err=0; then rx_addr=3 when 2 is expected → no write, load_err=1, load_done=0 after release.
- With AW=2, sending address 4 → rejected, load_err=1. enable falls → cpu_rst stays high exactly RELEASE_CYCLES=16 cycles, then drops and load_done stays 0.
- rst pulsed while the write for address 5 is staged → imem_we stays 0, all outputs return to reset values, state=IDLE.
- With UART_PROG_LOADER_CHECKSUM_EN defined:
  - words 1,2,3 and exp_sum=6 → load_done=1;
  - repeat with exp_sum=7 → load_done=0, load_err=1.
